uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_defs.sv | 9 +
 rtl/fifo_ram_dp.sv | 28 ++
 rtl/uart_rx_fifo.sv | 97 +++++++++
 tb/tb_uart_rx_fifo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART constants and types
package uart_defs;

  // Width of one UART character as delivered by the receiver
  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/fifo_ram_dp.sv
// rtl/fifo_ram_dp.sv - DEPTH x W storage, synchronous write, registered read, no reset
module fifo_ram_dp #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int W      = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_q
);

  logic [W-1:0] mem [0:DEPTH-1];

  // Write port; a same-address read in the same cycle returns the old word
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds its value until the next enabled read
  always_ff @(posedge clk) begin
    if (rd_en) rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO behind a UART receiver with edge-detected writes
module uart_rx_fifo
  import uart_defs::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_data_valid,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic              rx_data_valid_q;
  logic              wr_pulse;
  logic              rd_acc;
  logic              wr_acc;
  logic              drop;
  logic              rd_seen;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  uart_byte_t        ram_q;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign wr_pulse = rx_data_valid & ~rx_data_valid_q;
  // A read never bypasses a same-cycle write into an empty FIFO
  assign rd_acc   = rd_en & ~empty;
  // When full, a simultaneous read frees the slot the write lands in
  assign wr_acc   = wr_pulse & (~full | rd_acc);
  assign drop     = wr_pulse & full & ~rd_acc;
  // Storage has no reset, so rd_data reads as zero until the first pop
  assign rd_data  = rd_seen ? ram_q : '0;

  // Valid-level history; starting at 1 blocks a write for a level already high at reset release
  always_ff @(posedge clk) begin
    if (reset) rx_data_valid_q <= 1'b1;
    else       rx_data_valid_q <= rx_data_valid;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
    end
  end

  // Read strobe, one cycle behind the accepted read, and first-pop marker
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_seen  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_seen <= 1'b1;
    end
  end

  // Sticky drop flag; a drop in the clearing cycle keeps it set
  always_ff @(posedge clk) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  fifo_ram_dp #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (UART_DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (rx_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_q    (ram_q)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
  import uart_defs::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       clear_overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  // Monitor: every rd_valid pops one expected byte
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected got=%02h required=no rd_valid", rd_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL rd_data got=%02h required=%02h", rd_data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pulse(input logic [7:0] b);
    rx_data = b;
    rx_data_valid = 1'b1;
    step();
    rx_data_valid = 1'b0;
    step();
  endtask

  task automatic rd(input logic [7:0] e);
    exp_q.push_back(e);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("rd_valid_latency", {31'b0, rd_valid}, 32'd1);
    step();
    chk("rd_valid_pulse", {31'b0, rd_valid}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    rx_data = 8'h00;
    rx_data_valid = 1'b0;
    rd_en = 1'b0;
    clear_overflow = 1'b0;
    do_reset();
    chk("reset_count", {27'b0, count}, 32'd0);
    chk("reset_empty", {31'b0, empty}, 32'd1);
    chk("reset_full", {31'b0, full}, 32'd0);
    chk("reset_overflow", {31'b0, overflow}, 32'd0);
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset_rd_data", {24'b0, rd_data}, 32'h00);

    // Three bytes in, three out in order
    pulse(8'hA5);
    pulse(8'h3C);
    pulse(8'h0F);
    chk("three_count", {27'b0, count}, 32'd3);
    rd(8'hA5);
    rd(8'h3C);
    rd(8'h0F);
    chk("three_empty", {31'b0, empty}, 32'd1);
    step();
    step();
    chk("rd_data_hold", {24'b0, rd_data}, 32'h0F);

    // Long valid level writes once
    rx_data = 8'h55;
    rx_data_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rx_data_valid = 1'b0;
    step();
    chk("level_count", {27'b0, count}, 32'd1);
    rd(8'h55);
    chk("level_empty", {31'b0, empty}, 32'd1);

    // Fill past capacity
    for (int i = 0; i < 17; i++) begin
      pulse(8'h10 + 8'(i));
      if (i == 15) begin
        chk("fill_full", {31'b0, full}, 32'd1);
        chk("fill_no_ovf", {31'b0, overflow}, 32'd0);
      end
    end
    chk("ovf_set", {31'b0, overflow}, 32'd1);
    chk("ovf_count", {27'b0, count}, 32'd16);
    for (int i = 0; i < 16; i++) rd(8'h10 + 8'(i));
    chk("ovf_drained", {31'b0, empty}, 32'd1);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_cleared", {31'b0, overflow}, 32'd0);

    // Full FIFO with simultaneous write and read
    for (int i = 0; i < 16; i++) pulse(8'h20 + 8'(i));
    exp_q.push_back(8'h20);
    rx_data = 8'hEE;
    rx_data_valid = 1'b1;
    rd_en = 1'b1;
    step();
    rx_data_valid = 1'b0;
    rd_en = 1'b0;
    step();
    chk("wr_rd_full_count", {27'b0, count}, 32'd16);
    chk("wr_rd_full_ovf", {31'b0, overflow}, 32'd0);
    rx_data = 8'h99;
    rx_data_valid = 1'b1;
    clear_overflow = 1'b1;
    step();
    rx_data_valid = 1'b0;
    clear_overflow = 1'b0;
    chk("set_beats_clear", {31'b0, overflow}, 32'd1);
    step();
    for (int i = 1; i < 16; i++) rd(8'h20 + 8'(i));
    rd(8'hEE);
    chk("wr_rd_drained", {31'b0, empty}, 32'd1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;

    // Read on empty with same-cycle write: no bypass
    rx_data = 8'h77;
    rx_data_valid = 1'b1;
    rd_en = 1'b1;
    step();
    rx_data_valid = 1'b0;
    rd_en = 1'b0;
    chk("empty_rd_no_valid", {31'b0, rd_valid}, 32'd0);
    chk("empty_rd_count", {27'b0, count}, 32'd1);
    step();
    rd(8'h77);

    // Reset mid-operation with valid held high
    for (int i = 0; i < 5; i++) pulse(8'h40 + 8'(i));
    chk("pre_reset_count", {27'b0, count}, 32'd5);
    rx_data = 8'hAB;
    rx_data_valid = 1'b1;
    do_reset();
    step();
    step();
    chk("mid_reset_count", {27'b0, count}, 32'd0);
    chk("mid_reset_empty", {31'b0, empty}, 32'd1);
    chk("mid_reset_rd_data", {24'b0, rd_data}, 32'h00);
    rx_data_valid = 1'b0;
    step();
    chk("mid_reset_no_write", {27'b0, count}, 32'd0);
    pulse(8'hAB);
    chk("post_reset_write", {27'b0, count}, 32'd1);
    rd(8'hAB);
    step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
